i2cmb_wb_sequencer: RTL and testbench

- Wishbone master stage directly upstream of the iicmb_m_wb I2C multi-bus controller.
- Accepts one high-level I2C transaction request at a time, given as op, bus, 7-bit slave address and byte count.
- Expands each request into the controller's CSR/DPR/CMDR register accesses.
- Waits for command completion, streams write data in and read data out, then reports done or an error code.

---
 rtl/i2cmb_wb_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that expands one I2C transaction into iicmb_m_wb CSR/DPR/CMDR accesses.
// Build option: define I2CMB_SEQ_POLL_EN to poll CMDR instead of waiting on irq_i.
module i2cmb_wb_sequencer #(
  parameter int NUM_I2C_BUSSES = 16,
  parameter int LEN_WIDTH      = 8,
  parameter int WAIT_TIMEOUT   = 1000000,
  parameter int POLL_GAP       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_rd_i,
  input  logic [3:0]           req_bus_i,
  input  logic [6:0]           req_addr_i,
  input  logic [LEN_WIDTH-1:0] req_len_i,
  input  logic                 wr_valid_i,
  input  logic [7:0]           wr_data_i,
  output logic                 wr_ready_o,
  output logic                 rd_valid_o,
  output logic [7:0]           rd_data_o,
  output logic                 rd_last_o,
  output logic                 done_o,
  output logic [1:0]           err_o,
  output logic                 busy_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [1:0]           adr_o,
  output logic [7:0]           dat_o,
  input  logic [7:0]           dat_i,
  input  logic                 ack_i,
  input  logic                 irq_i
);

  // state      | meaning
  // INIT       | program CSR after reset
  // IDLE       | ready for a request
  // BUS        | Wishbone access in flight, continue at ret_st on ack
  // SETBUS_*   | DPR=bus, CMDR=set-bus
  // START      | CMDR=start
  // ADDR_*     | DPR={addr,rd}, CMDR=write
  // DATA       | choose next byte, or STOP when count is exhausted
  // WR_*       | take a write byte, DPR=byte, CMDR=write
  // RD_*       | CMDR=read ack/nak, read DPR, present byte
  // STOP       | CMDR=stop
  // WAIT/CHK   | wait for completion, decode CMDR status
  // GAP        | idle between CMDR polls (poll build only)
  // FINISH     | done_o pulse with err_o
  localparam logic [4:0] S_INIT     = 5'd0,  S_IDLE     = 5'd1,  S_BUS      = 5'd2,
                         S_SETBUS_D = 5'd3,  S_SETBUS_C = 5'd4,  S_START    = 5'd5,
                         S_ADDR_D   = 5'd6,  S_ADDR_C   = 5'd7,  S_DATA     = 5'd8,
                         S_WR_HOLD  = 5'd9,  S_WR_D     = 5'd10, S_WR_C     = 5'd11,
                         S_RD_C     = 5'd12, S_RD_D     = 5'd13, S_RD_OUT   = 5'd14,
                         S_STOP     = 5'd15, S_WAIT     = 5'd16, S_WAIT_CHK = 5'd17,
                         S_GAP      = 5'd18, S_FINISH   = 5'd19;

  localparam logic [1:0] ADR_CSR = 2'd0, ADR_DPR = 2'd1, ADR_CMDR = 2'd2;
  localparam logic [7:0] CMD_WRITE  = 8'h01, CMD_RD_ACK = 8'h02, CMD_RD_NAK = 8'h03,
                         CMD_START  = 8'h04, CMD_STOP   = 8'h05, CMD_SETBUS = 8'h06;
`ifdef I2CMB_SEQ_POLL_EN
  localparam logic [7:0] CSR_INIT = 8'h80;
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
  logic [GW-1:0] gap;
`else
  localparam logic [7:0] CSR_INIT = 8'hC0;
`endif
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(WAIT_TIMEOUT - 1);

  logic [4:0]           state, ret_st, caller;
  logic [TW-1:0]        tmr;
  logic [3:0]           bus_q;
  logic [6:0]           addr_q;
  logic                 rd_q, last_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [7:0]           wbyte, rdat;
  logic [1:0]           err_q;

  assign req_ready_o = (state == S_IDLE);
  assign wr_ready_o  = (state == S_WR_HOLD) && wr_valid_i;
  assign done_o      = (state == S_FINISH);
  assign err_o       = done_o ? err_q : 2'b00;

  task automatic wb_start(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                          input logic [4:0] ret);
    cyc_o  <= 1'b1;
    stb_o  <= 1'b1;
    we_o   <= we;
    adr_o  <= adr;
    dat_o  <= dat;
    ret_st <= ret;
    state  <= S_BUS;
  endtask

  // The completion timer restarts with every command issued.
  task automatic issue_cmd(input logic [7:0] code, input logic [4:0] after);
    wb_start(1'b1, ADR_CMDR, code, S_WAIT);
    caller <= after;
    tmr    <= TMR_LOAD;
  endtask

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_INIT;  ret_st <= S_INIT;  caller <= S_INIT;
      tmr <= '0;  cnt <= '0;  bus_q <= '0;  addr_q <= '0;  rd_q <= 1'b0;  last_q <= 1'b0;
      wbyte <= '0;  rdat <= '0;  err_q <= '0;  busy_o <= 1'b0;
      rd_valid_o <= 1'b0;  rd_data_o <= '0;  rd_last_o <= 1'b0;
      cyc_o <= 1'b0;  stb_o <= 1'b0;  we_o <= 1'b0;  adr_o <= '0;  dat_o <= '0;
`ifdef I2CMB_SEQ_POLL_EN
      gap <= '0;
`endif
    end else begin
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      case (state)
        S_INIT: wb_start(1'b1, ADR_CSR, CSR_INIT, S_IDLE);
        S_IDLE: if (req_valid_i) begin
          bus_q  <= req_bus_i;
          addr_q <= req_addr_i;
          rd_q   <= req_rd_i;
          cnt    <= req_len_i;
          busy_o <= 1'b1;
          if (int'(req_bus_i) >= NUM_I2C_BUSSES) begin
            err_q <= 2'd3;
            state <= S_FINISH;
          end else begin
            err_q <= 2'd0;
            state <= S_SETBUS_D;
          end
        end
        S_BUS: if (ack_i) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          rdat  <= dat_i;
          state <= ret_st;
        end
        S_SETBUS_D: wb_start(1'b1, ADR_DPR, {4'h0, bus_q}, S_SETBUS_C);
        S_SETBUS_C: issue_cmd(CMD_SETBUS, S_START);
        S_START:    issue_cmd(CMD_START, S_ADDR_D);
        S_ADDR_D:   wb_start(1'b1, ADR_DPR, {addr_q, rd_q}, S_ADDR_C);
        S_ADDR_C:   issue_cmd(CMD_WRITE, S_DATA);
        S_DATA:
          if (cnt == '0) state <= S_STOP;
          else if (rd_q) state <= S_RD_C;
          else           state <= S_WR_HOLD;
        S_WR_HOLD: if (wr_valid_i) begin
          wbyte <= wr_data_i;
          state <= S_WR_D;
        end
        S_WR_D: wb_start(1'b1, ADR_DPR, wbyte, S_WR_C);
        S_WR_C: begin
          cnt <= cnt - 1'b1;
          issue_cmd(CMD_WRITE, S_DATA);
        end
        S_RD_C: begin
          last_q <= (cnt == LEN_WIDTH'(1));
          cnt    <= cnt - 1'b1;
          issue_cmd((cnt == LEN_WIDTH'(1)) ? CMD_RD_NAK : CMD_RD_ACK, S_RD_D);
        end
        S_RD_D: wb_start(1'b0, ADR_DPR, 8'h00, S_RD_OUT);
        S_RD_OUT: begin
          rd_valid_o <= 1'b1;
          rd_data_o  <= rdat;
          rd_last_o  <= last_q;
          state      <= S_DATA;
        end
        S_STOP: issue_cmd(CMD_STOP, S_FINISH);
        S_WAIT:
          if (tmr == '0) begin
            err_q <= 2'd3;
            state <= S_FINISH;
          end else begin
            tmr <= tmr - 1'b1;
`ifdef I2CMB_SEQ_POLL_EN
            wb_start(1'b0, ADR_CMDR, 8'h00, S_WAIT_CHK);
`else
            if (irq_i) wb_start(1'b0, ADR_CMDR, 8'h00, S_WAIT_CHK);
`endif
          end
        S_WAIT_CHK:
`ifdef I2CMB_SEQ_POLL_EN
          if (rdat[7:4] == 4'h0) begin
            gap   <= GAP_LOAD;
            state <= S_GAP;
          end else
`endif
          // AL/ERR is checked first so it overrides an earlier or simultaneous NAK.
          if (rdat[5] || rdat[4]) begin
            err_q <= 2'd2;
            state <= S_FINISH;
          end else if (rdat[6]) begin
            if (err_q == 2'd0) err_q <= 2'd1;
            state <= (caller == S_FINISH) ? S_FINISH : S_STOP;
          end else begin
            state <= caller;
          end
`ifdef I2CMB_SEQ_POLL_EN
        S_GAP:
          if (tmr == '0) begin
            err_q <= 2'd3;
            state <= S_FINISH;
          end else begin
            tmr <= tmr - 1'b1;
            if (gap == '0) state <= S_WAIT;
            else           gap   <= gap - 1'b1;
          end
`endif
        S_FINISH: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: behavioural iicmb_m_wb register model with scoreboard
// queues for Wishbone accesses, read bytes and completion codes.
module tb_i2cmb_wb_sequencer;
  localparam int NB = 12;
  localparam int LW = 8;
  localparam int WT = 100;

  logic          clk_i = 1'b0, rst_i = 1'b0;
  logic          req_valid_i = 1'b0, req_rd_i = 1'b0;
  logic [3:0]    req_bus_i = '0;
  logic [6:0]    req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic          wr_valid_i = 1'b0;
  logic [7:0]    wr_data_i = '0;
  logic          req_ready_o, wr_ready_o, rd_valid_o, rd_last_o, done_o, busy_o;
  logic [7:0]    rd_data_o, dat_o;
  logic [1:0]    err_o, adr_o;
  logic          cyc_o, stb_o, we_o;
  logic [7:0]    dat_i = '0;
  logic          ack_i = 1'b0, irq_i = 1'b0;

  i2cmb_wb_sequencer #(.NUM_I2C_BUSSES(NB), .LEN_WIDTH(LW), .WAIT_TIMEOUT(WT), .POLL_GAP(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i), .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i));

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0;
  int wb_cnt = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0, cyc_n = 0;
  int irq_cnt = 0, last_cmd_cyc = 0, done_cyc = 0;
  bit irq_mute = 1'b0;
  logic [7:0]  cur_stat = 8'h80;
  logic [10:0] exp_wb[$];
  logic [8:0]  exp_rd[$];
  logic [1:0]  exp_done[$];
  logic [7:0]  stat_q[$], dpr_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc_n++;

  // Controller register model: acks each access one cycle after stb, raises irq a few
  // cycles after every CMDR command, and clears irq on the CMDR status read.
  initial begin
    logic [10:0] obs, exp;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        ack_i = 1'b0; irq_i = 1'b0; irq_cnt = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) irq_i = 1'b1;
        end
        if (ack_i) ack_i = 1'b0;
        else if (cyc_o && stb_o) begin
          obs = {we_o, adr_o, we_o ? dat_o : 8'h00};
          exp = (exp_wb.size() > 0) ? exp_wb.pop_front() : 11'h7FF;
          check_val("wb_access", 32'(obs), 32'(exp));
          wb_cnt++;
          dat_i = 8'h00;
          if (we_o && adr_o == 2'd2) begin
            cur_stat = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h80;
            last_cmd_cyc = cyc_n;
            if (!irq_mute) irq_cnt = 3;
          end
          if (!we_o && adr_o == 2'd2) begin
            dat_i = cur_stat;
            irq_i = 1'b0;
          end
          if (!we_o && adr_o == 2'd1) dat_i = (dpr_q.size() > 0) ? dpr_q.pop_front() : 8'h00;
          ack_i = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc_n;
        e = (exp_done.size() > 0) ? 32'(exp_done.pop_front()) : 32'hDEAD;
        check_val("done_err", 32'(err_o), e);
      end
      if (rd_valid_o) begin
        rd_cnt++;
        e = (exp_rd.size() > 0) ? 32'(exp_rd.pop_front()) : 32'hDEAD;
        check_val("rd_byte", 32'({rd_last_o, rd_data_o}), e);
      end
      if (wr_ready_o) wr_cnt++;
    end
  end

  task automatic exp_w(input logic [1:0] adr, input logic [7:0] dat);
    exp_wb.push_back({1'b1, adr, dat});
  endtask

  task automatic exp_cmd(input logic [7:0] code);
    exp_w(2'd2, code);
    exp_wb.push_back({1'b0, 2'd2, 8'h00});
  endtask

  task automatic exp_rdpr();
    exp_wb.push_back({1'b0, 2'd1, 8'h00});
  endtask

  task automatic exp_head(input logic [3:0] bus, input logic [6:0] addr, input logic rd);
    exp_w(2'd1, {4'h0, bus});
    exp_cmd(8'h06);
    exp_cmd(8'h04);
    exp_w(2'd1, {addr, rd});
    exp_cmd(8'h01);
  endtask

  task automatic send_req(input logic rd, input logic [3:0] bus, input logic [6:0] addr,
                          input logic [LW-1:0] len);
    req_rd_i = rd; req_bus_i = bus; req_addr_i = addr; req_len_i = len; req_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (req_ready_o) break;
    end
    check_val("req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) begin
      @(posedge clk_i); #1;
    end
    check_val("done_seen", 32'(done_cnt - start), 32'd1);
    check_val("ready_after_done", 32'({req_ready_o, done_o}), 32'b10);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !req_ready_o; i++) begin
      @(posedge clk_i); #1;
    end
    check_val(tag, 32'(req_ready_o), 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check_val(tag, 32'(exp_wb.size() + exp_rd.size() + exp_done.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, b0, d0, lat;
    logic [7:0] wbytes[2];
    wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;

    // reset and CSR initialisation
    exp_w(2'd0, 8'hC0);
    repeat (3) @(posedge clk_i);
    #1;
    check_val("reset_outs", 32'({cyc_o, stb_o, req_ready_o, done_o, busy_o, rd_valid_o, wr_ready_o}), 32'd0);
    rst_i = 1'b1;
    wait_ready("init_ready");
    check_drained("init_drained");
    repeat (20) @(posedge clk_i);
    #1;
    check_val("init_single_wb", 32'(wb_cnt), 32'd1);

    // write bus 5, addr 0x22, two bytes
    exp_head(4'd5, 7'h22, 1'b0);
    exp_w(2'd1, 8'hA5); exp_cmd(8'h01);
    exp_w(2'd1, 8'h3C); exp_cmd(8'h01);
    exp_cmd(8'h05);
    exp_done.push_back(2'd0);
    w0 = wr_cnt;
    send_req(1'b0, 4'd5, 7'h22, 8'd2);
    check_val("busy_after_accept", 32'({busy_o, req_ready_o}), 32'b10);
    foreach (wbytes[k]) begin
      wr_valid_i = 1'b1;
      wr_data_i  = wbytes[k];
      for (int i = 0; i < 500; i++) begin
        @(negedge clk_i);
        if (wr_ready_o) break;
      end
      @(posedge clk_i); #1;
    end
    wr_valid_i = 1'b0;
    wait_done(500);
    check_val("wr_ready_pulses", 32'(wr_cnt - w0), 32'd2);
    check_drained("write_drained");

    // read bus 0, addr 0x22, three bytes
    exp_head(4'd0, 7'h22, 1'b1);
    exp_cmd(8'h02); exp_rdpr();
    exp_cmd(8'h02); exp_rdpr();
    exp_cmd(8'h03); exp_rdpr();
    exp_cmd(8'h05);
    dpr_q = '{8'h11, 8'h22, 8'h33};
    exp_rd = '{9'h011, 9'h022, 9'h133};
    exp_done.push_back(2'd0);
    r0 = rd_cnt;
    send_req(1'b1, 4'd0, 7'h22, 8'd3);
    wait_done(600);
    check_val("rd_count", 32'(rd_cnt - r0), 32'd3);
    check_drained("read_drained");

    // address-only probe
    exp_head(4'd6, 7'h11, 1'b0);
    exp_cmd(8'h05);
    exp_done.push_back(2'd0);
    send_req(1'b0, 4'd6, 7'h11, 8'd0);
    wait_done(400);
    check_drained("probe_drained");

    // address NAK: STOP then err=1, write data never consumed
    stat_q = '{8'h80, 8'h80, 8'hC0};
    exp_head(4'd1, 7'h50, 1'b0);
    exp_cmd(8'h05);
    exp_done.push_back(2'd1);
    w0 = wr_cnt;
    wr_valid_i = 1'b1; wr_data_i = 8'h77;
    send_req(1'b0, 4'd1, 7'h50, 8'd1);
    wait_done(400);
    wr_valid_i = 1'b0;
    check_val("nak_no_wr_ready", 32'(wr_cnt - w0), 32'd0);
    check_drained("nak_drained");

    // arbitration lost on START: err=2, no STOP
    stat_q = '{8'h80, 8'h20};
    exp_w(2'd1, 8'h02); exp_cmd(8'h06); exp_cmd(8'h04);
    exp_done.push_back(2'd2);
    send_req(1'b0, 4'd2, 7'h33, 8'd1);
    wait_done(400);
    check_drained("al_drained");

    // NAK and AL together on the address: AL wins
    stat_q = '{8'h80, 8'h80, 8'h60};
    exp_head(4'd4, 7'h33, 1'b1);
    exp_done.push_back(2'd2);
    send_req(1'b1, 4'd4, 7'h33, 8'd2);
    wait_done(400);
    check_drained("nak_al_drained");

    // bus index out of range: immediate err=3, no bus traffic
    b0 = wb_cnt;
    exp_done.push_back(2'd3);
    send_req(1'b0, 4'd13, 7'h10, 8'd1);
    check_val("badbus_done_now", 32'({done_o, err_o}), 32'b111);
    wait_done(20);
    check_val("badbus_no_wb", 32'(wb_cnt - b0), 32'd0);
    check_drained("badbus_drained");

    // irq never arrives: timeout after WT cycles, no STOP
    irq_mute = 1'b1;
    exp_w(2'd1, 8'h03); exp_w(2'd2, 8'h06);
    exp_done.push_back(2'd3);
    send_req(1'b0, 4'd3, 7'h10, 8'd1);
    wait_done(WT + 200);
    lat = done_cyc - last_cmd_cyc;
    check_val("timeout_latency", 32'(lat >= WT && lat <= WT + 2), 32'd1);
    irq_mute = 1'b0;
    check_drained("timeout_drained");

    // reset in the data phase of a read
    exp_head(4'd0, 7'h22, 1'b1);
    exp_cmd(8'h02); exp_rdpr();
    exp_cmd(8'h02); exp_rdpr();
    exp_cmd(8'h03); exp_rdpr();
    exp_cmd(8'h05);
    dpr_q = '{8'h11, 8'h22, 8'h33};
    exp_rd = '{9'h011, 9'h022, 9'h133};
    exp_done.push_back(2'd0);
    r0 = rd_cnt;
    d0 = done_cnt;
    send_req(1'b1, 4'd0, 7'h22, 8'd3);
    for (int i = 0; i < 500 && rd_cnt == r0; i++) begin
      @(posedge clk_i); #1;
    end
    check_val("rst_reached_data", 32'(rd_cnt - r0), 32'd1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_val("rst_drop", 32'({cyc_o, stb_o, done_o, busy_o, req_ready_o}), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    exp_wb.delete(); exp_rd.delete(); exp_done.delete(); dpr_q.delete(); stat_q.delete();
    exp_w(2'd0, 8'hC0);
    b0 = wb_cnt;
    rst_i = 1'b1;
    wait_ready("reinit_ready");
    check_val("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("reinit_single_wb", 32'(wb_cnt - b0), 32'd1);
    check_drained("reinit_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
